flash_port_arbiter: RTL and testbench
=====================================

Name: flash_port_arbiter

Overview:
- Shares the single Wishbone read port of the SPI flash reader between two requesters.
  - Port 0: CPU-side boot ROM fetch sequencer.
  - Port 1: secondary fetcher, e.g. audio sample or config loader.
- Single-beat, non-pipelined reads only; one transaction outstanding at a time.
- Adds fixed or round-robin arbitration, abort on requester withdrawal, and a bus timeout that returns an error instead of hanging the CPU cycle.

Parameters:
- AW, 22, word address width (24-bit flash byte space, longword granularity).
- DW, 32, data width.
- RR_EN, 0, 0 = fixed priority (port 0 always wins), 1 = round-robin.
- TIMEOUT, 255, max cycles from issue to s_ack before abort; range 1..65535.

Ports:
- Clocking and reset:
  - clk  in  1  system clock
  - rst  in  1  reset, asynchronous, active-low
- Port 0 (requester):
  - m0_cyc  in  1  port 0 cycle
  - m0_stb  in  1  port 0 strobe
  - m0_addr  in  AW  port 0 word address
  - m0_sel  in  4  port 0 byte selects
  - m0_stall  out  1  port 0 request not accepted this cycle
  - m0_ack  out  1  port 0 read complete, one-cycle pulse
  - m0_err  out  1  port 0 timeout error, one-cycle pulse
- Port 1 (requester):
  - m1_cyc, m1_stb, m1_addr, m1_sel, m1_stall, m1_ack, m1_err: same as port 0.
- Shared read data:
  - m_data  out  DW  read data, shared by both ports, valid when the matching ack is high
- Flash-side port:
  - s_cyc  out  1  cycle to flash reader
  - s_stb  out  1  strobe to flash reader
  - s_addr  out  AW  registered address
  - s_sel  out  4  registered byte selects
  - s_stall  in  1  flash reader stall
  - s_ack  in  1  flash reader ack
  - s_data  in  DW  flash reader data

Behaviour:
- Reset values:
  - s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err = 0.
  - s_addr, s_sel, m_data = 0; state = IDLE.
  - last_grant = 1, so port 0 wins first in RR mode.
  - Timeout counter = 0.
  - While rst is low, m0_stall and m1_stall = 1.
- Request and stall rules:
  - reqN = mN_cyc & mN_stb.
  - mN_stall is combinational: low only in the cycle where state == IDLE and port N is selected winner; high otherwise.
- Winner selection:
  - Fixed mode: port 0 whenever req0.
  - RR mode: the port other than last_grant wins when both request; the sole requester otherwise.
- States:
  - IDLE:
    - On any req, latch winner's addr/sel into s_addr/s_sel and record grant.
    - Set s_cyc = s_stb = 1 and clear the timeout counter; go ISSUE.
    - s_cyc is 0 throughout IDLE.
  - ISSUE:
    - Hold s_stb until a cycle with s_stall = 0, then drop s_stb; go WAIT.
  - WAIT:
    - On s_ack: m_data <= s_data, pulse mN_ack for the granted port (registered, 1 cycle).
    - Set s_cyc = 0 and last_grant <= grant; go IDLE.
- Latency:
  - Request accepted cycle T; s_stb high T+1.
  - With no stall, WAIT from T+2.
  - s_ack at cycle K gives mN_ack at K+1.
  - Back-to-back requests: the next acceptance is possible in the cycle after ack (IDLE).
- Timeout:
  - Counter increments every cycle in ISSUE and WAIT.
  - When it equals TIMEOUT with no s_ack that cycle: s_cyc = s_stb = 0, pulse mN_err for the granted port, go IDLE; last_grant is still updated.
  - s_ack in the same cycle as expiry: ack wins, no err.
- Requester withdrawal:
  - Granted mN_cyc drops in ISSUE or WAIT: s_cyc = s_stb = 0 next cycle, go IDLE, no ack/err.
  - A coincident s_ack is discarded; m_data is not updated.
- s_cyc minimum low time: after any completion or abort, s_cyc stays 0 for at least one cycle (the IDLE cycle), so the flash reader resets its SPI transaction.
- A non-granted port's ack and err are never asserted.
- Port N never sees ack and err together.
- Async reset mid-transaction: all outputs go to reset values immediately; no ack or err is produced for the aborted read.

Decomposition:
- Shared package, flash_arb_pkg:
  - State encoding: IDLE, ISSUE, WAIT.
  - Grant encoding constants: GNT_M0 = 0, GNT_M1 = 1.
  - Default widths for AW and DW.
- One natural sub-module, arb2_pick: combinational two-way winner select from req0, req1, last_grant, RR_EN.
- Timeout counter stays inline.

Test Plan:
- Single read: m0 requests addr 0x000100, s_stall low 2 cycles then s_ack at cycle 6 with 0xDEADBEEF -> m0_ack at cycle 7, m_data = 0xDEADBEEF, m1_ack stays 0, s_addr = 0x000100.
- Contention, RR_EN = 0: both request continuously, 4 reads -> all four grants go to port 0; m1_stall stays 1.
- Contention, RR_EN = 1: both request continuously -> grants alternate 0,1,0,1; s_cyc low one cycle between each.
- Timeout, TIMEOUT = 8: m1 request, no s_ack -> s_cyc drops and m1_err pulses exactly 9 cycles after issue; m1_ack never asserted.
  - Repeat with s_ack on the expiry cycle -> m1_ack, no err.
- Withdrawal: m0 drops m0_cyc in WAIT at the same cycle as s_ack -> no m0_ack, m_data unchanged, state IDLE next cycle.
- Reset mid-read: rst low during WAIT -> s_cyc = 0 and both stalls = 1 immediately; after release, the first RR grant goes to port 0.

Source files
------------

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-port SPI flash read arbiter.
package flash_arb_pkg;

    // Transaction state of the shared flash-side port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Grant encoding: the grant value is the port index.
    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    // Default widths: 22-bit longword address covers a 24-bit byte space.
    localparam int DEF_AW = 22;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/arb2_pick.sv
// Two-way winner select: fixed priority (port 0) or round-robin against last grant.
module arb2_pick
    import flash_arb_pkg::*;
#(
    parameter int RR_EN = 0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_any,
    output logic o_winner
);

    // Winner is only meaningful while o_any is high.
    always_comb begin
        o_any    = i_req0 | i_req1;
        o_winner = GNT_M0;
        if ((RR_EN != 0) && i_req0 && i_req1)
            o_winner = ~i_last_grant;
        else if (!i_req0 && i_req1)
            o_winner = GNT_M1;
    end

endmodule

// File: rtl/flash_port_arbiter.sv
// Shares the single-beat Wishbone read port of the SPI flash reader between
// two requesters, with requester-withdrawal abort and a bus timeout.
module flash_port_arbiter
    import flash_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int RR_EN   = 0,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    // port 0
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic [AW-1:0] m0_addr,
    input  logic [3:0]    m0_sel,
    output logic          m0_stall,
    output logic          m0_ack,
    output logic          m0_err,
    // port 1
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic [AW-1:0] m1_addr,
    input  logic [3:0]    m1_sel,
    output logic          m1_stall,
    output logic          m1_ack,
    output logic          m1_err,
    // shared read data
    output logic [DW-1:0] m_data,
    // flash side
    output logic          s_cyc,
    output logic          s_stb,
    output logic [AW-1:0] s_addr,
    output logic [3:0]    s_sel,
    input  logic          s_stall,
    input  logic          s_ack,
    input  logic [DW-1:0] s_data
);

    localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

    arb_state_t  r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [15:0] r_cnt;

    logic w_any;
    logic w_winner;
    logic w_gnt_cyc;
    logic w_accept;

    arb2_pick #(.RR_EN(RR_EN)) u_pick (
        .i_req0       (m0_cyc & m0_stb),
        .i_req1       (m1_cyc & m1_stb),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_winner     (w_winner)
    );

    // Granted requester still holding its cycle; dropping it aborts the read.
    assign w_gnt_cyc = (r_grant == GNT_M1) ? m1_cyc : m0_cyc;

    // Stall is released only for the winner in the accepting IDLE cycle;
    // the rst term keeps both stalled while reset is asserted.
    assign w_accept = rst && (r_state == ST_IDLE) && w_any;
    assign m0_stall = !(w_accept && (w_winner == GNT_M0));
    assign m1_stall = !(w_accept && (w_winner == GNT_M1));

    // Transaction FSM with registered flash-side and requester outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_M0;
            r_last_grant <= GNT_M1;
            r_cnt        <= '0;
            s_cyc        <= 1'b0;
            s_stb        <= 1'b0;
            s_addr       <= '0;
            s_sel        <= '0;
            m_data       <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_err       <= 1'b0;
            m1_err       <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // s_cyc is held low for this cycle so the reader ends
                    // its SPI transaction before the next one starts.
                    s_cyc <= 1'b0;
                    s_stb <= 1'b0;
                    if (w_any) begin
                        s_addr  <= (w_winner == GNT_M1) ? m1_addr : m0_addr;
                        s_sel   <= (w_winner == GNT_M1) ? m1_sel  : m0_sel;
                        r_grant <= w_winner;
                        s_cyc   <= 1'b1;
                        s_stb   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (!w_gnt_cyc) begin
                        // Withdrawal: silent abort, any coincident ack is dropped.
                        s_cyc        <= 1'b0;
                        s_stb        <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end else if ((r_state == ST_WAIT) && s_ack) begin
                        // Ack beats a coincident timeout expiry.
                        m_data       <= s_data;
                        m0_ack       <= (r_grant == GNT_M0);
                        m1_ack       <= (r_grant == GNT_M1);
                        s_cyc        <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end else if (r_cnt == TO_CNT) begin
                        s_cyc        <= 1'b0;
                        s_stb        <= 1'b0;
                        m0_err       <= (r_grant == GNT_M0);
                        m1_err       <= (r_grant == GNT_M1);
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end else if ((r_state == ST_ISSUE) && !s_stall) begin
                        s_stb   <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Directed bench: one fixed-priority and one round-robin arbiter share the
// same stimulus; both use TIMEOUT = 8.
module tb_flash_port_arbiter;
    localparam int AW = 22;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_cyc = 0, m0_stb = 0, m1_cyc = 0, m1_stb = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [3:0]    m0_sel = '0, m1_sel = '0;
    logic          s_stall = 0, s_ack = 0;
    logic [DW-1:0] s_data = '0;

    logic          m0_stall_f, m0_ack_f, m0_err_f, m1_stall_f, m1_ack_f, m1_err_f;
    logic          s_cyc_f, s_stb_f;
    logic [AW-1:0] s_addr_f;
    logic [3:0]    s_sel_f;
    logic [DW-1:0] m_data_f;
    logic          m0_stall_r, m0_ack_r, m0_err_r, m1_stall_r, m1_ack_r, m1_err_r;
    logic          s_cyc_r, s_stb_r;
    logic [AW-1:0] s_addr_r;
    logic [3:0]    s_sel_r;
    logic [DW-1:0] m_data_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    flash_port_arbiter #(.AW(AW), .DW(DW), .RR_EN(0), .TIMEOUT(8)) u_fix (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_addr(m0_addr), .m0_sel(m0_sel),
        .m0_stall(m0_stall_f), .m0_ack(m0_ack_f), .m0_err(m0_err_f),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_addr(m1_addr), .m1_sel(m1_sel),
        .m1_stall(m1_stall_f), .m1_ack(m1_ack_f), .m1_err(m1_err_f),
        .m_data(m_data_f), .s_cyc(s_cyc_f), .s_stb(s_stb_f), .s_addr(s_addr_f),
        .s_sel(s_sel_f), .s_stall(s_stall), .s_ack(s_ack), .s_data(s_data)
    );

    flash_port_arbiter #(.AW(AW), .DW(DW), .RR_EN(1), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_addr(m0_addr), .m0_sel(m0_sel),
        .m0_stall(m0_stall_r), .m0_ack(m0_ack_r), .m0_err(m0_err_r),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_addr(m1_addr), .m1_sel(m1_sel),
        .m1_stall(m1_stall_r), .m1_ack(m1_ack_r), .m1_err(m1_err_r),
        .m_data(m_data_r), .s_cyc(s_cyc_r), .s_stb(s_stb_r), .s_addr(s_addr_r),
        .s_sel(s_sel_r), .s_stall(s_stall), .s_ack(s_ack), .s_data(s_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_scyc",   s_cyc_f, 0);
        chk("rst_sstb",   s_stb_f, 0);
        chk("rst_stall0", m0_stall_f, 1);
        chk("rst_stall1", m1_stall_r, 1);
        chk("rst_mdata",  m_data_f, 0);
        chk("rst_saddr",  s_addr_f, 0);
        chk("rst_acks",   {m0_ack_f, m1_ack_f, m0_err_f, m1_err_f}, 0);
        rst = 1'b1;

        // ---------------- single read on port 0 ----------------
        tick();
        m0_cyc = 1; m0_stb = 1; m0_addr = 22'h000100; m0_sel = 4'hF;
        #1;
        chk("single_stall0_idle", m0_stall_f, 0);
        chk("single_stall1_idle", m1_stall_f, 1);
        tick();                               // accept edge
        m0_stb = 0; s_stall = 1;
        chk("single_scyc",  s_cyc_f, 1);
        chk("single_sstb",  s_stb_f, 1);
        chk("single_saddr", s_addr_f, 22'h000100);
        chk("single_ssel",  s_sel_f, 4'hF);
        tick();                               // stalled, still ISSUE
        chk("single_stb_hold", s_stb_f, 1);
        s_stall = 0;
        tick();                               // WAIT
        chk("single_stb_drop", s_stb_f, 0);
        chk("single_cyc_wait", s_cyc_f, 1);
        tick();
        s_ack = 1; s_data = 32'hDEADBEEF;
        chk("single_no_early_ack", m0_ack_f, 0);
        tick();
        s_ack = 0; m0_cyc = 0;
        chk("single_ack0",  m0_ack_f, 1);
        chk("single_ack1",  m1_ack_f, 0);
        chk("single_mdata", m_data_f, 32'hDEADBEEF);
        chk("single_scyc_low", s_cyc_f, 0);
        tick();
        chk("single_ack_pulse", m0_ack_f, 0);

        // ---------------- contention, both modes ----------------
        rst = 0; #1; rst = 1;
        m0_cyc = 1; m0_stb = 1; m0_addr = 22'h000010;
        m1_cyc = 1; m1_stb = 1; m1_addr = 22'h000020;
        s_stall = 0;
        for (int i = 0; i < 4; i++) begin
            logic exp_g;
            exp_g = i[0];                     // round-robin: 0,1,0,1
            #1;
            chk("cont_fix_stall0", m0_stall_f, 0);
            chk("cont_fix_stall1", m1_stall_f, 1);
            chk("cont_rr_stall0",  m0_stall_r, exp_g != 0);
            chk("cont_rr_stall1",  m1_stall_r, exp_g != 1);
            chk("cont_rr_idle_cyc", s_cyc_r, 0);
            tick();
            chk("cont_rr_cyc", s_cyc_r, 1);
            chk("cont_rr_addr", s_addr_r, exp_g ? 22'h000020 : 22'h000010);
            tick();
            s_ack = 1; s_data = 32'hA0 + i;
            tick();
            s_ack = 0;
            chk("cont_fix_ack0", m0_ack_f, 1);
            chk("cont_fix_ack1", m1_ack_f, 0);
            chk("cont_rr_ack0",  m0_ack_r, exp_g == 0);
            chk("cont_rr_ack1",  m1_ack_r, exp_g == 1);
            chk("cont_rr_data",  m_data_r, 32'hA0 + i);
        end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        // ---------------- timeout on port 1 ----------------
        m1_cyc = 1; m1_stb = 1; m1_addr = 22'h000300;
        tick();                               // accept; issue cycle follows
        m1_stb = 0;
        chk("to_issue_cyc", s_cyc_r, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("to_no_err", m1_err_r, 0);
            chk("to_cyc_held", s_cyc_r, 1);
        end
        tick();                               // 9 cycles after issue
        m1_cyc = 0;
        chk("to_err_rr",  m1_err_r, 1);
        chk("to_err_fix", m1_err_f, 1);
        chk("to_no_ack",  m1_ack_r, 0);
        chk("to_no_err0", m0_err_r, 0);
        chk("to_scyc",    s_cyc_r, 0);
        tick();
        chk("to_err_pulse", m1_err_r, 0);

        // timeout with ack on the expiry cycle: ack wins
        m1_cyc = 1; m1_stb = 1;
        tick();
        m1_stb = 0;
        for (int k = 1; k <= 8; k++) tick();
        s_ack = 1; s_data = 32'h12345678;
        tick();
        s_ack = 0; m1_cyc = 0;
        chk("to_ack_wins", m1_ack_r, 1);
        chk("to_ack_noerr", m1_err_r, 0);
        chk("to_ack_data", m_data_r, 32'h12345678);
        tick();

        // ---------------- withdrawal in WAIT with coincident ack ----------------
        m0_cyc = 1; m0_stb = 1; m0_addr = 22'h000200;
        tick();
        m0_stb = 0;
        tick();                               // WAIT
        m0_cyc = 0; s_ack = 1; s_data = 32'h00000BAD;
        tick();
        s_ack = 0;
        chk("wd_no_ack", m0_ack_r, 0);
        chk("wd_no_err", m0_err_r, 0);
        chk("wd_scyc",   s_cyc_r, 0);
        chk("wd_mdata",  m_data_r, 32'h12345678);
        m0_cyc = 1; m0_stb = 1; #1;
        chk("wd_idle", m0_stall_r, 0);
        // accept a port 0 read so the round-robin arbiter records grant 0
        tick();
        m0_stb = 0;
        tick();                               // WAIT

        // ---------------- async reset mid-read ----------------
        rst = 0; #1;
        chk("rr_rst_scyc",   s_cyc_r, 0);
        chk("rr_rst_stall0", m0_stall_r, 1);
        chk("rr_rst_stall1", m1_stall_r, 1);
        tick();
        rst = 1;
        m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        #1;
        chk("rr_post_rst_g0", m0_stall_r, 0);
        chk("rr_post_rst_g1", m1_stall_r, 1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        chk("rr_post_rst_noack", {m0_ack_r, m1_ack_r, m0_err_r, m1_err_r}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
